// File: rtl/seq_pkg.sv
// Shared definitions for the serial stream transmitter and the 1011 sequence detector.
package seq_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_GAP   = 2'd2
  } txState_e;

  // Pattern the downstream detector looks for; the stream source and the bench share it.
  localparam logic [3:0] SEQ_PATTERN = 4'b1011;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load shift register with a bit-index counter that flags the last bit of a word.
module piso_shift #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              bit_o,
  output logic              last_bit_o
);

  localparam int CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [DATA_W-1:0] shReg_q, shReg_d;
  logic [CntW-1:0]   bitCnt_q, bitCnt_d;

  // A load always wins over a shift so that a chained word restarts the index at 0.
  always_comb begin
    shReg_d  = shReg_q;
    bitCnt_d = bitCnt_q;
    if (load_i) begin
      shReg_d  = data_i;
      bitCnt_d = '0;
    end else if (shift_i) begin
      shReg_d  = MSB_FIRST ? {shReg_q[DATA_W-2:0], 1'b0} : {1'b0, shReg_q[DATA_W-1:1]};
      bitCnt_d = bitCnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shReg_q  <= '0;
      bitCnt_q <= '0;
    end else begin
      shReg_q  <= shReg_d;
      bitCnt_q <= bitCnt_d;
    end
  end

  assign bit_o      = MSB_FIRST ? shReg_q[DATA_W-1] : shReg_q[0];
  assign last_bit_o = (bitCnt_q == LastIdx);

endmodule

// File: rtl/seq_stream_tx.sv
// Serializes handshaked words into a one-bit stream with optional idle gaps and a word counter.
module seq_stream_tx
  import seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              stream,
  output logic              stream_valid,
  output logic              word_done,
  output logic [CNT_W-1:0]  tx_count
);

  localparam bit              HasGap  = (GAP_CYCLES > 0);
  localparam logic [3:0]      GapLast = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  txState_e         state_q, state_d;
  logic [3:0]       gapCnt_q, gapCnt_d;
  logic [CNT_W-1:0] txCount_q, txCount_d;
  logic             pisoBit;
  logic             lastBit;
  logic             xfer;

  assign xfer = in_valid && in_ready;

  piso_shift #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_piso (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (xfer),
    .shift_i   ((state_q == TX_SHIFT) && !lastBit),
    .data_i    (in_data),
    .bit_o     (pisoBit),
    .last_bit_o(lastBit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      gapCnt_q  <= '0;
      txCount_q <= '0;
    end else begin
      state_q   <= state_d;
      gapCnt_q  <= gapCnt_d;
      txCount_q <= txCount_d;
    end
  end

  // The word counter advances on the closing edge of the last-bit cycle.
  always_comb begin
    state_d   = state_q;
    gapCnt_d  = gapCnt_q;
    txCount_d = txCount_q;
    case (state_q)
      TX_IDLE: begin
        if (xfer) state_d = TX_SHIFT;
      end
      TX_SHIFT: begin
        if (lastBit) begin
          txCount_d = txCount_q + CntOne;
          if (HasGap) begin
            state_d  = TX_GAP;
            gapCnt_d = '0;
          end else if (xfer) begin
            state_d = TX_SHIFT;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      TX_GAP: begin
        if (gapCnt_q == GapLast) state_d = TX_IDLE;
        else                     gapCnt_d = gapCnt_q + 4'd1;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Chaining without a bubble is only possible when no gap follows the word.
  always_comb begin
    in_ready     = (state_q == TX_IDLE) || ((state_q == TX_SHIFT) && lastBit && !HasGap);
    stream_valid = (state_q == TX_SHIFT);
    stream       = (state_q == TX_SHIFT) && pisoBit;
    word_done    = (state_q == TX_SHIFT) && lastBit;
  end

  assign tx_count = txCount_q;

endmodule

// File: tb/tb_seq_stream_tx.sv
// Bench for seq_stream_tx: four configurations checked every cycle against a symbol-queue model.
module tb_seq_stream_tx;
  import seq_pkg::*;

  localparam int NInst  = 4;
  localparam int LogLen = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inValid [NInst];
  logic [7:0] inData  [NInst];
  logic       readyW  [NInst];
  logic       streamW [NInst];
  logic       validW  [NInst];
  logic       doneW   [NInst];
  logic [15:0] txCountW [NInst];

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: defaults, 1: three gap cycles, 2: LSB first, 3: 4-bit word counter.
  for (genvar g = 0; g < NInst; g++) begin : g_dut
    localparam int CntW = (g == 3) ? 4 : 16;
    logic [CntW-1:0] cnt;
    seq_stream_tx #(
      .DATA_W    (8),
      .MSB_FIRST ((g == 2) ? 1'b0 : 1'b1),
      .GAP_CYCLES((g == 1) ? 3 : 0),
      .CNT_W     (CntW)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (inData[g]),
      .in_valid    (inValid[g]),
      .in_ready    (readyW[g]),
      .stream      (streamW[g]),
      .stream_valid(validW[g]),
      .word_done   (doneW[g]),
      .tx_count    (cnt)
    );
    assign txCountW[g] = 16'(cnt);
  end

  function automatic int gapOf(input int g);
    return (g == 1) ? 3 : 0;
  endfunction

  function automatic bit msbOf(input int g);
    return (g != 2);
  endfunction

  function automatic logic [15:0] maskOf(input int g);
    return (g == 3) ? 16'h000F : 16'hFFFF;
  endfunction

  // Model: each accepted word becomes a queue of per-cycle symbols {last, valid, bit}
  // followed by idle symbols for the gap; one symbol is consumed per clock.
  logic [2:0]  mq [NInst][64];
  int          mHead [NInst];
  int          mSize [NInst];
  logic [15:0] mCount [NInst];

  function automatic bit modelReady(input int g);
    return (mSize[g] == 0) || (gapOf(g) == 0 && mSize[g] == 1);
  endfunction

  task automatic pushWord(input int g, input logic [7:0] d);
    int idx;
    for (int i = 0; i < 8; i++) begin
      idx = msbOf(g) ? 7 - i : i;
      mq[g][(mHead[g] + mSize[g]) % 64] = {(i == 7), 1'b1, d[idx]};
      mSize[g]++;
    end
    for (int i = 0; i < gapOf(g); i++) begin
      mq[g][(mHead[g] + mSize[g]) % 64] = 3'b000;
      mSize[g]++;
    end
  endtask

  initial begin
    for (int g = 0; g < NInst; g++) begin
      mHead[g] = 0; mSize[g] = 0; mCount[g] = '0;
      inValid[g] = 1'b0; inData[g] = '0;
    end
  end

  always @(posedge clk) begin
    bit rdy;
    logic [2:0] sym;
    for (int g = 0; g < NInst; g++) begin
      if (!rst_n) begin
        mHead[g] = 0; mSize[g] = 0; mCount[g] = '0;
      end else begin
        rdy = modelReady(g);
        if (mSize[g] > 0) begin
          sym = mq[g][mHead[g]];
          mHead[g] = (mHead[g] + 1) % 64;
          mSize[g]--;
          if (sym[2]) mCount[g] = mCount[g] + 16'd1;
        end
        if (rdy && inValid[g]) pushWord(g, inData[g]);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] sym;
    if (checkEn) begin
      for (int g = 0; g < NInst; g++) begin
        sym = (mSize[g] > 0) ? mq[g][mHead[g]] : 3'b000;
        checkOutput($sformatf("stream[%0d]", g), 32'(streamW[g]), 32'(sym[0]));
        checkOutput($sformatf("stream_valid[%0d]", g), 32'(validW[g]), 32'(sym[1]));
        checkOutput($sformatf("word_done[%0d]", g), 32'(doneW[g]), 32'(sym[2]));
        checkOutput($sformatf("in_ready[%0d]", g), 32'(readyW[g]), 32'(modelReady(g)));
        checkOutput($sformatf("tx_count[%0d]", g), 32'(txCountW[g]), 32'(mCount[g] & maskOf(g)));
      end
    end
  end

  // Per-cycle trace plus a reference overlapping 1011 detector on instance 0.
  logic        logStream [NInst][LogLen];
  logic        logValid  [NInst][LogLen];
  logic        logDone   [NInst][LogLen];
  logic        logReady  [NInst][LogLen];
  logic [15:0] logCount  [NInst][LogLen];
  logic        logMatch  [LogLen];
  logic [3:0]  hist = 4'b0000;

  always @(negedge clk) begin
    if (cyc < LogLen) begin
      for (int g = 0; g < NInst; g++) begin
        logStream[g][cyc] = streamW[g];
        logValid[g][cyc]  = validW[g];
        logDone[g][cyc]   = doneW[g];
        logReady[g][cyc]  = readyW[g];
        logCount[g][cyc]  = txCountW[g];
      end
      hist = {hist[2:0], streamW[0]};
      logMatch[cyc] = (hist == SEQ_PATTERN);
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Presents a word and returns 2 time units after the transfer edge (output cycle 1).
  task automatic applyStimulus(input int g, input logic [7:0] d);
    int n;
    logic r;
    inData[g]  = d;
    inValid[g] = 1'b1;
    n = 0;
    r = 1'b0;
    while (!r && n < 100) begin
      @(negedge clk);
      r = readyW[g];
      @(posedge clk);
      #2;
      n++;
    end
    inValid[g] = 1'b0;
    if (!r) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL handshake[%0d]: in_ready got 0 expected 1 within 100 cycles", g);
    end
  endtask

  function automatic logic [7:0] captureByte(input int g, input int c0);
    logic [7:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w = {w[6:0], logStream[g][c0 + k]};
    return w;
  endfunction

  function automatic int countOnes(input int sel, input int g, input int c0, input int len);
    int s;
    s = 0;
    for (int k = 0; k < len; k++) begin
      case (sel)
        0: s += logValid[g][c0 + k] ? 1 : 0;
        1: s += logDone[g][c0 + k] ? 1 : 0;
        2: s += logReady[g][c0 + k] ? 1 : 0;
        default: s += logMatch[c0 + k] ? 1 : 0;
      endcase
    end
    return s;
  endfunction

  initial begin
    int c0;
    rst_n = 1'b0;
    waitCycles(1);
    checkEn = 1'b1;
    waitCycles(2);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset in_ready", 32'(readyW[0]), 32'd1);
    checkOutput("reset stream_valid", 32'(validW[0]), 32'd0);
    checkOutput("reset tx_count", 32'(txCountW[0]), 32'd0);
    waitCycles(1);

    // Reset lands on the closing edge of bit 4 of 8'hFF.
    applyStimulus(0, 8'hFF);
    waitCycles(3);
    checkOutput("abort pre-reset stream", 32'(streamW[0]), 32'd1);
    rst_n = 1'b0;
    waitCycles(1);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort stream", 32'(streamW[0]), 32'd0);
    checkOutput("abort stream_valid", 32'(validW[0]), 32'd0);
    checkOutput("abort in_ready", 32'(readyW[0]), 32'd1);
    checkOutput("abort tx_count", 32'(txCountW[0]), 32'd0);
    waitCycles(1);

    applyStimulus(0, 8'hB0);
    c0 = cyc;
    waitCycles(10);
    checkOutput("B0 bits", 32'(captureByte(0, c0)), 32'hB0);
    checkOutput("B0 word_done cycle 8", 32'(logDone[0][c0 + 7]), 32'd1);
    checkOutput("B0 word_done count", 32'(countOnes(1, 0, c0, 10)), 32'd1);
    checkOutput("B0 match cycle 4", 32'(logMatch[c0 + 3]), 32'd1);
    checkOutput("B0 match count", 32'(countOnes(3, 0, c0, 10)), 32'd1);
    checkOutput("B0 tx_count", 32'(txCountW[0]), 32'd1);

    applyStimulus(0, 8'h0B);
    c0 = cyc;
    applyStimulus(0, 8'h0B);
    waitCycles(12);
    checkOutput("b2b valid run", 32'(countOnes(0, 0, c0, 16)), 32'd16);
    checkOutput("b2b valid after", 32'(logValid[0][c0 + 16]), 32'd0);
    checkOutput("b2b ready count", 32'(countOnes(2, 0, c0, 15)), 32'd1);
    checkOutput("b2b ready cycle 8", 32'(logReady[0][c0 + 7]), 32'd1);
    checkOutput("b2b match count", 32'(countOnes(3, 0, c0, 16)), 32'd2);
    checkOutput("b2b match cycle 8", 32'(logMatch[c0 + 7]), 32'd1);
    checkOutput("b2b match cycle 16", 32'(logMatch[c0 + 15]), 32'd1);
    checkOutput("b2b tx_count", 32'(txCountW[0]), 32'd3);

    applyStimulus(1, 8'hA5);
    c0 = cyc;
    applyStimulus(1, 8'h3C);
    waitCycles(12);
    for (int k = 8; k < 11; k++) begin
      checkOutput("gap stream_valid", 32'(logValid[1][c0 + k]), 32'd0);
      checkOutput("gap stream", 32'(logStream[1][c0 + k]), 32'd0);
      checkOutput("gap in_ready", 32'(logReady[1][c0 + k]), 32'd0);
    end
    checkOutput("gap idle in_ready", 32'(logReady[1][c0 + 11]), 32'd1);
    checkOutput("gap idle stream_valid", 32'(logValid[1][c0 + 11]), 32'd0);
    checkOutput("gap second word start", 32'(logValid[1][c0 + 12]), 32'd1);
    checkOutput("gap second word bits", 32'(captureByte(1, c0 + 12)), 32'h3C);
    checkOutput("gap tx_count", 32'(txCountW[1]), 32'd2);

    applyStimulus(2, 8'h0D);
    c0 = cyc;
    waitCycles(10);
    checkOutput("lsb bits", 32'(captureByte(2, c0)), 32'hB0);
    checkOutput("lsb tx_count", 32'(txCountW[2]), 32'd1);

    applyStimulus(3, 8'h00);
    c0 = cyc;
    for (int i = 1; i < 17; i++) applyStimulus(3, 8'(i));
    waitCycles(10);
    checkOutput("wrap after 15", 32'(logCount[3][c0 + 120]), 32'h0F);
    checkOutput("wrap after 16", 32'(logCount[3][c0 + 128]), 32'h00);
    checkOutput("wrap after 17", 32'(logCount[3][c0 + 136]), 32'h01);

    waitCycles(2);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/seq_stream_tx.md
Name: seq_stream_tx

Overview:
Parallel-to-serial transmitter that produces the one-bit serial stream consumed by the sequence-detection FSM (1011 detector).
- Accepts DATA_W-bit words over a valid/ready handshake and shifts them out one bit per clock, MSB first by default.
- Optionally inserts idle gap cycles between words.
- Counts transmitted words so the bench can correlate detector matches with injected words.

Parameters:
- DATA_W, 8: word width in bits, legal range 2..32.
- MSB_FIRST, 1: 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- GAP_CYCLES, 0: idle cycles inserted after each word, legal range 0..15. During a gap, stream=0 and stream_valid=0.
- CNT_W, 16: width of the word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  DATA_W  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  transmitter can accept a word this cycle.
- stream  output  1  serial data bit, registered; drives the detector's stream input.
- stream_valid  output  1  stream carries a data bit this cycle.
- word_done  output  1  one-cycle pulse, coincident with the last bit of a word.
- tx_count  output  CNT_W  number of words fully transmitted; wraps.

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low.
- Reset values (rst_n=0 sampled at a clk edge): state=IDLE, stream=0, stream_valid=0, word_done=0, tx_count=0, in_ready=1 from the first cycle after reset. Shift register and bit counter are cleared.
- States:
  - IDLE: no word in flight.
  - SHIFT: word being serialized.
  - GAP: inter-word idle.
- Handshake:
  - Transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - in_ready is combinational from state: 1 in IDLE; 1 in SHIFT only on the last-bit cycle when GAP_CYCLES=0; 0 otherwise.
  - in_ready never depends on in_valid.
  - in_data is not required to be stable after the transfer edge.
- Latency: on the transfer edge, the first bit and stream_valid=1 are registered, so they are visible in the cycle immediately after the handshake.
- Bit ordering: with MSB_FIRST=1, a word is output as DATA_W consecutive cycles of bits [DATA_W-1] down to [0]. With MSB_FIRST=0, the order is [0] up to [DATA_W-1].
- Bit counter: counts 0..DATA_W-1. On the cycle carrying bit index DATA_W-1 (the last bit sent):
  - word_done=1;
  - tx_count increments on that cycle's closing edge (mod 2^CNT_W; wrap 2^CNT_W-1 -> 0 without a flag).
- End of word:
  - GAP_CYCLES=0 with a new transfer on the last-bit edge: the new word's first bit follows with no bubble (continuous stream).
  - GAP_CYCLES=0 without a new transfer: go to IDLE.
  - GAP_CYCLES>0: go to GAP for exactly GAP_CYCLES cycles, then IDLE. A word is accepted in IDLE only.
- Idle and gap output: stream is forced to 0 whenever stream_valid=0. The detector treats idle as 0 bits, so a pattern split across a gap is not detected, except where zeros are part of the pattern.
- Reset mid-word: the word in flight is discarded, outputs return to reset values on the next cycle, and tx_count is not incremented.
- in_valid held high in IDLE: the word is accepted on the first edge. Values of in_valid while in_ready=0 are ignored (no implicit buffering).

Decomposition:
- Package seq_pkg:
  - state encoding constants TX_IDLE=2'd0, TX_SHIFT=2'd1, TX_GAP=2'd2;
  - the pattern constant SEQ_PATTERN=4'b1011, shared with the detector and the bench.
- Sub-module piso_shift (DATA_W, MSB_FIRST):
  - load/shift register plus bit counter;
  - outputs the current bit and a last_bit flag.
- Top seq_stream_tx contains the FSM, gap counter, tx_count and handshake logic.

Test Plan:
- Single word, DATA_W=8, MSB_FIRST=1, in_data=8'hB0 -> stream 1,0,1,1,0,0,0,0 on cycles 1..8 after the handshake; word_done on cycle 8; tx_count=1; a chained Mealy detector pulses match exactly once, on cycle 4.
- Back-to-back, GAP_CYCLES=0, words 8'h0B then 8'h0B with in_valid held high -> 16 contiguous stream_valid cycles; in_ready=1 only on cycle 8 while in SHIFT; detector match on cycles 8 and 16; tx_count=2.
- GAP_CYCLES=3, two words -> stream_valid low for exactly 3 cycles between words with stream=0; in_ready low during the gap and high in IDLE.
- MSB_FIRST=0, in_data=8'h0D -> stream 1,0,1,1,0,0,0,0.
- Reset asserted on bit 4 of 8'hFF -> next cycle stream=0, stream_valid=0, in_ready=1, tx_count unchanged; a following word 8'hB0 is sent correctly.
- CNT_W=4, 17 words -> tx_count reads 4'hF after word 15, 0 after word 16, 1 after word 17.
